fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 54 +++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Purpose : bundles the program-memory, decoder and control signals of the
//           instruction fetch unit so they travel as one port.
// Signals :
//   address       fetch unit -> memory   program memory address (= PC)
//   I             memory -> fetch unit   instruction word at address
//   instr         fetch unit -> decoder  registered instruction
//   instr_valid   fetch unit -> decoder  instr holds an unconsumed word
//   instr_ready   decoder -> fetch unit  decoder accepts instr this cycle
//   branch_en     core -> fetch unit     one-cycle redirect pulse
//   branch_target core -> fetch unit     absolute redirect address
//   halt          core -> fetch unit     level request to stop fetching
//   halted        fetch unit -> core     fetch FSM is in HALTED
// Modports: master = fetch unit side, slave = environment side.
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int Psize = 6,
    parameter int Isize = 17
);
    logic [Psize-1:0] address;
    logic [Isize-1:0] I;
    logic [Isize-1:0] instr;
    logic             instr_valid;
    logic             instr_ready;
    logic             branch_en;
    logic [Psize-1:0] branch_target;
    logic             halt;
    logic             halted;

    modport master (
        output address,
        input  I,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  branch_en,
        input  branch_target,
        input  halt,
        output halted
    );

    modport slave (
        input  address,
        output I,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output branch_en,
        output branch_target,
        output halt,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Purpose : instruction fetch stage. Holds the PC, presents it to the program
//           memory combinationally, registers the returned word into a
//           single-entry valid/ready output buffer, supports absolute
//           redirects (branch) and a RUN/HALTED control FSM.
// Ports   :
//   clk          rising-edge clock
//   nReset       asynchronous active-low reset
//   bus          fetch_unit_if.master (address, I, instr, instr_valid,
//                instr_ready, branch_en, branch_target, halt, halted)
//   fetch_count  16-bit saturating count of loads; only present when the
//                macro FETCH_PERF_COUNT_EN is defined
// Parameters:
//   Psize  program address width (memory holds 2^Psize words)
//   Isize  instruction word width
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int Psize = 6,
    parameter int Isize = 17
) (
    input  logic          clk,
    input  logic          nReset,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [15:0]   fetch_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [Psize-1:0] pc_q, pc_d;
    logic [Isize-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             loadEn;

    // The output buffer can accept a new word when it is empty or being
    // drained this cycle. A branch always wins, so the word fetched from the
    // old PC is never loaded on a redirect edge.
    always_comb begin
        loadEn = (state_q == RUN) && !bus.branch_en &&
                 (!valid_q || bus.instr_ready);
    end

    // Control FSM: halt is a level, so each state simply follows it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.halt)  state_d = HALTED;
            HALTED:  if (!bus.halt) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // PC and output buffer next state. A redirect flushes the buffered word
    // even if the decoder is accepting it this cycle; it also updates the PC
    // while halted so fetch resumes from the new target.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bus.branch_en) begin
            pc_d    = bus.branch_target;
            valid_d = 1'b0;
        end else if (loadEn) begin
            pc_d    = pc_q + Psize'(1);
            instr_d = bus.I;
            valid_d = 1'b1;
        end else if (valid_q && bus.instr_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset discards any stalled or in-flight word.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= RUN;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] count_q, count_d;

    // Count real loads only, holding at all-ones instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (loadEn && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`endif

    assign bus.address     = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Purpose : self-checking bench for fetch_unit. A behavioural model keeps the
//           architectural view (PC, buffered word, halted flag, load count)
//           and is advanced one clock at a time from the block's rules; a
//           program memory array answers the DUT's address combinationally.
//           Define FETCH_PERF_COUNT_EN to also check fetch_count.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int Psize = 6;
    localparam int Isize = 17;
    localparam int Depth = 1 << Psize;

    logic clk;
    logic nReset;

    fetch_unit_if #(.Psize(Psize), .Isize(Isize)) bus ();

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetchCount;
`endif

    fetch_unit #(.Psize(Psize), .Isize(Isize)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .bus         (bus)
`ifdef FETCH_PERF_COUNT_EN
        ,
        .fetch_count (fetchCount)
`endif
    );

    // Program memory seen by the DUT.
    logic [Isize-1:0] mem [Depth];

    always_comb begin
        bus.I = mem[bus.address];
    end

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state.
    int               mPc;
    int               mInstr;
    bit               mValid;
    bit               mHalted;
    int               mCount;

    int checkCount;
    int passCount;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d expected %0d (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("address",     32'(bus.address),     32'(mPc));
        checkOutput("instr",       32'(bus.instr),       32'(mInstr));
        checkOutput("instr_valid", 32'(bus.instr_valid), 32'(mValid));
        checkOutput("halted",      32'(bus.halted),      32'(mHalted));
`ifdef FETCH_PERF_COUNT_EN
        checkOutput("fetch_count", 32'(fetchCount),      32'(mCount));
`endif
    endtask

    function automatic void modelReset();
        mPc     = 0;
        mInstr  = 0;
        mValid  = 0;
        mHalted = 0;
        mCount  = 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the next rising
    // edge, then compare once outputs have settled.
    task automatic applyStimulus(input bit rdy, input bit br, input int tgt,
                                 input bit hlt);
        int  nPc;
        int  nInstr;
        bit  nValid;
        int  nCount;
        bit  canTake;
        bus.instr_ready   = rdy;
        bus.branch_en     = br;
        bus.branch_target = Psize'(tgt);
        bus.halt          = hlt;
        nPc     = mPc;
        nInstr  = mInstr;
        nValid  = mValid;
        nCount  = mCount;
        canTake = !mValid || rdy;
        if (br) begin
            nPc    = tgt;
            nValid = 0;
        end else if (!mHalted && canTake) begin
            nInstr = int'(mem[mPc]);
            nValid = 1;
            nPc    = (mPc + 1) % Depth;
            if (mCount < 65535) nCount = mCount + 1;
        end else if (mValid && rdy) begin
            nValid = 0;
        end
        @(posedge clk);
        #1;
        mPc     = nPc;
        mInstr  = nInstr;
        mValid  = nValid;
        mCount  = nCount;
        mHalted = hlt;
        checkAll();
    endtask

    // Asynchronous reset pulse taken between edges; checked before any edge.
    task automatic pulseReset();
        #2;
        nReset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        nReset = 1'b1;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        for (int k = 0; k < Depth; k++) mem[k] = Isize'(k);
        bus.instr_ready   = 1'b1;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;
        bus.halt          = 1'b0;
        nReset            = 1'b0;
        modelReset();
        #2;
        checkAll();
        @(negedge clk);
        nReset = 1'b1;

        // Streaming from word 0 at one word per cycle.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("streamInstr3", 32'(bus.instr), 32'd3);
        checkOutput("streamAddr4",  32'(bus.address), 32'd4);

        // Run through the top of memory and wrap.
        for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("preWrapInstr", 32'(bus.instr), 32'd63);
        checkOutput("wrapAddr",     32'(bus.address), 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("postWrapInstr", 32'(bus.instr), 32'd0);

        // Back-pressure stall with word 5 buffered.
        pulseReset();
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("stallInstr", 32'(bus.instr), 32'd5);
        checkOutput("stallAddr",  32'(bus.address), 32'd6);
        applyStimulus(1, 0, 0, 0);
        checkOutput("unstallInstr", 32'(bus.instr), 32'd6);

        // Redirect while word 7 is being accepted.
        pulseReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 20, 0);
        checkOutput("flushValid", 32'(bus.instr_valid), 32'd0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("branchInstr", 32'(bus.instr), 32'd20);
        checkOutput("branchValid", 32'(bus.instr_valid), 32'd1);

        // Halt, drain, branch while halted, resume, reset mid-halt.
        pulseReset();
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1);
        checkOutput("haltDrain", 32'(bus.instr_valid), 32'd0);
        applyStimulus(1, 1, 40, 1);
        checkOutput("haltBranchPc", 32'(bus.address), 32'd40);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("resumeInstr", 32'(bus.instr), 32'd40);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        pulseReset();

        // Ten loads, a branch, three loads.
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 30, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
`ifdef FETCH_PERF_COUNT_EN
        checkOutput("count13", 32'(fetchCount), 32'd13);
`endif

        // Randomized traffic with random memory contents.
        for (int k = 0; k < Depth; k++) mem[k] = Isize'($urandom_range(0, (1 << Isize) - 1));
        begin
            bit hlt;
            hlt = 0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 99) < 6) hlt = !hlt;
                if ($urandom_range(0, 99) < 2) begin
                    pulseReset();
                end else begin
                    applyStimulus($urandom_range(0, 3) != 0,
                                  $urandom_range(0, 9) == 0,
                                  int'($urandom_range(0, Depth - 1)), hlt);
                end
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
